// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared state encoding, mode constants and RAM geometry for the BIST sequencer.
package ram_bist_pkg;
  localparam int AW_DEF = 14;
  localparam int DW_DEF = 16;
  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/ram_bist_cmp.sv
// ram_bist_cmp: delays {valid, address, expected} by the read latency, compares with RAM data, counts errors.
module ram_bist_cmp import ram_bist_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] exp_i,
  input  logic [DW-1:0] dout_i,
  output logic [AW:0]   err_cnt_o,
  output logic [AW-1:0] first_err_adr_o,
  output logic          err_flag_o
);
  logic          vld_p [RD_LAT];
  logic [AW-1:0] adr_p [RD_LAT];
  logic [DW-1:0] exp_p [RD_LAT];
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] fea_q, fea_d;
  logic          flag_q, flag_d, mis;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        vld_p[k] <= 1'b0;
        adr_p[k] <= '0;
        exp_p[k] <= '0;
      end
      cnt_q <= '0;
      fea_q <= '0;
      flag_q <= 1'b0;
    end else begin
      vld_p[0] <= vld_i;
      adr_p[0] <= adr_i;
      exp_p[0] <= exp_i;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        adr_p[k] <= adr_p[k-1];
        exp_p[k] <= exp_p[k-1];
      end
      cnt_q <= cnt_d;
      fea_q <= fea_d;
      flag_q <= flag_d;
    end
  end
  // Only the first mismatch of a command (count still zero) captures the address.
  always_comb begin
    mis = vld_p[RD_LAT-1] && (dout_i != exp_p[RD_LAT-1]);
    cnt_d = clr_i ? '0 : mis ? cnt_q + (AW+1)'(1) : cnt_q;
    fea_d = clr_i ? '0 : (mis && cnt_q == '0) ? adr_p[RD_LAT-1] : fea_q;
    flag_d = clr_i ? 1'b0 : flag_q | mis;
  end
  assign err_cnt_o = cnt_q;
  assign first_err_adr_o = fea_q;
  assign err_flag_o = flag_q;
endmodule

// File: rtl/ram_bist_sequencer.sv
// ram_bist_sequencer: runs FILL/VERIFY commands over a wrapping address range of the 16K x 16 RAM.
module ram_bist_sequencer import ram_bist_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] base_adr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] seed,
  input  logic [DW-1:0] step,
  output logic          busy,
  output logic          done,
  output logic          ram_e,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  output logic          ram_w,
  output logic          ram_r,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_adr,
  output logic          err_flag
);
  state_e        state_q, state_d;
  logic          mode_q, mode_d, run, clr;
  logic [AW:0]   len_q, len_d, idx_q, idx_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] exp_q, exp_d, step_q, step_d;
  logic [2:0]    dcnt_q, dcnt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= MODE_FILL;
      len_q <= '0;
      idx_q <= '0;
      adr_q <= '0;
      exp_q <= '0;
      step_q <= '0;
      dcnt_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      len_q <= len_d;
      idx_q <= idx_d;
      adr_q <= adr_d;
      exp_q <= exp_d;
      step_q <= step_d;
      dcnt_q <= dcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    len_d = len_q;
    idx_d = idx_q;
    adr_d = adr_q;
    exp_d = exp_q;
    step_d = step_q;
    dcnt_d = dcnt_q;
    clr = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        clr = 1'b1;
        mode_d = mode;
        len_d = len;
        step_d = step;
        adr_d = base_adr;
        exp_d = seed;
        idx_d = '0;
        state_d = (len != '0) ? RUN : DONE;
      end
      RUN: begin
        adr_d = adr_q + AW'(1);
        exp_d = exp_q + step_q;
        idx_d = idx_q + (AW+1)'(1);
        dcnt_d = '0;
        if (idx_q == len_q - (AW+1)'(1)) state_d = (mode_q == MODE_VERIFY) ? DRAIN : DONE;
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 3'd1;
        if (dcnt_q == 3'(RD_LAT - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign run = (state_q == RUN);
  assign busy = run || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign ram_e = run;
  assign ram_w = run && (mode_q == MODE_FILL);
  assign ram_r = run && (mode_q == MODE_VERIFY);
  assign ram_adr = run ? adr_q : '0;
  assign ram_din = ram_w ? exp_q : '0;
  ram_bist_cmp #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_cmp (
    .clk(clk),
    .rst(rst),
    .clr_i(clr),
    .vld_i(ram_r),
    .adr_i(adr_q),
    .exp_i(exp_q),
    .dout_i(ram_dout),
    .err_cnt_o(err_cnt),
    .first_err_adr_o(first_err_adr),
    .err_flag_o(err_flag)
  );
endmodule

// File: tb/tb_ram_bist_sequencer.sv
// tb_ram_bist_sequencer: scoreboard bench with a behavioural 1-cycle-latency RAM.
module tb_ram_bist_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [13:0] base_adr = '0, ram_adr, first_err_adr;
  logic [14:0] len = '0, err_cnt;
  logic [15:0] seed = '0, step = '0, ram_din, ram_dout = '0;
  logic        busy, done, ram_e, ram_w, ram_r, err_flag;
  logic [15:0] mem [16384];
  logic [29:0] wq [$];
  logic [13:0] rq [$];
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ram_bist_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_adr(base_adr),
    .len(len), .seed(seed), .step(step), .busy(busy), .done(done),
    .ram_e(ram_e), .ram_adr(ram_adr), .ram_din(ram_din), .ram_w(ram_w),
    .ram_r(ram_r), .ram_dout(ram_dout), .err_cnt(err_cnt),
    .first_err_adr(first_err_adr), .err_flag(err_flag)
  );

  always @(posedge clk) begin
    if (ram_e && ram_w) mem[ram_adr] <= ram_din;
    if (ram_e && ram_r) ram_dout <= mem[ram_adr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_e !== (ram_w ^ ram_r)) chk("ram_e", 32'(ram_e), 32'(ram_w ^ ram_r));
    if (ram_w) begin
      if (wq.size() == 0) chk("w_extra", 32'(ram_adr), 32'hFFFF_FFFF);
      else begin
        logic [29:0] e;
        e = wq.pop_front();
        chk("w_adr", 32'(ram_adr), 32'(e[29:16]));
        chk("w_dat", 32'(ram_din), 32'(e[15:0]));
      end
    end
    if (ram_r) begin
      if (rq.size() == 0) chk("r_extra", 32'(ram_adr), 32'hFFFF_FFFF);
      else chk("r_adr", 32'(ram_adr), 32'(rq.pop_front()));
      chk("r_din0", 32'(ram_din), 0);
    end
  end

  task automatic do_cmd(input logic m, input logic [13:0] b, input logic [14:0] l,
                        input logic [15:0] sd, input logic [15:0] st, input int exp_cyc,
                        input bit glitch);
    int got = -1, bad = 0;
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] d;
      d = sd + 16'(i) * st;
      if (m) rq.push_back(14'(int'(b) + i));
      else wq.push_back({14'(int'(b) + i), d});
    end
    @(negedge clk);
    start = 1'b1; mode = m; base_adr = b; len = l; seed = sd; step = st;
    @(posedge clk);
    #1;
    start = 1'b0; base_adr = 14'($urandom); len = 15'($urandom); seed = 16'($urandom); step = 16'($urandom);
    for (int c = 1; c <= exp_cyc + 5 && got < 0; c++) begin
      @(negedge clk);
      if (done) begin
        got = c;
        if (busy) bad++;
      end else if (!busy) bad++;
      if (glitch && c == 2) begin start = 1'b1; mode = 1'b1; len = 15'd3; base_adr = '0; end
      if (glitch && c == 3) start = 1'b0;
      if (glitch && done) begin start = 1'b1; mode = 1'b1; len = 15'd3; end
    end
    chk("done_cyc", 32'(got), 32'(exp_cyc));
    chk("busy", 32'(bad), 0);
    @(negedge clk);
    start = 1'b0;
    chk("post_done", {30'd0, busy, done}, 0);
    chk("q_left", 32'(wq.size() + rq.size()), 0);
  endtask

  initial begin
    int dn;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {26'd0, busy, done, ram_e, ram_w, ram_r, err_flag}, 0);
    chk("rst_err", {3'd0, err_cnt, first_err_adr}, 0);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(1'b0, 14'd5, 15'd4, 16'd7, 16'd7, 5, 0);
    chk("mem6", 32'(mem[6]), 14);
    do_cmd(1'b1, 14'd5, 15'd4, 16'd7, 16'd7, 6, 0);
    chk("v_err", {3'd0, err_cnt, first_err_adr}, 0);
    chk("v_flag", 32'(err_flag), 0);
    mem[6] = 16'hFFFF;
    mem[8] = 16'h0;
    do_cmd(1'b1, 14'd5, 15'd4, 16'd7, 16'd7, 6, 0);
    chk("c_cnt", 32'(err_cnt), 2);
    chk("c_first", 32'(first_err_adr), 6);
    chk("c_flag", 32'(err_flag), 1);
    do_cmd(1'b0, 14'd16382, 15'd4, 16'd0, 16'd1, 5, 0);
    chk("fill_clr", {16'd0, err_cnt, err_flag}, 0);
    do_cmd(1'b1, 14'd16382, 15'd4, 16'd0, 16'd1, 6, 0);
    chk("wrap_err", 32'(err_cnt), 0);
    do_cmd(1'b0, 14'd9, 15'd0, 16'd1, 16'd1, 1, 0);
    do_cmd(1'b1, 14'd9, 15'd0, 16'd1, 16'd1, 1, 0);
    do_cmd(1'b0, 14'd0, 15'd16384, 16'd3, 16'd5, 16385, 0);
    chk("full_last", 32'(mem[16383]), 32'(16'(16'd3 + 16'd16383 * 16'd5)));
    do_cmd(1'b0, 14'd20, 15'd6, 16'h1234, 16'h0101, 7, 1);
    do_cmd(1'b1, 14'd20, 15'd6, 16'h1234, 16'h0101, 8, 0);
    chk("glitch_err", 32'(err_cnt), 0);
    mem[22] = 16'h0;
    do_cmd(1'b1, 14'd20, 15'd6, 16'h1234, 16'h0101, 8, 0);
    chk("pre_rst_flag", 32'(err_flag), 1);
    for (int i = 0; i < 2; i++) wq.push_back({14'(100 + i), 16'(1 + i)});
    @(negedge clk);
    start = 1'b1; mode = 1'b0; base_adr = 14'd100; len = 15'd10; seed = 16'd1; step = 16'd1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_ctl", {26'd0, busy, done, ram_e, ram_w, ram_r, err_flag}, 0);
    chk("ar_adr", {2'd0, ram_adr, ram_din}, 0);
    chk("ar_err", {3'd0, err_cnt, first_err_adr}, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("ar_quiet", 32'(dn), 0);
    chk("ar_q", 32'(wq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_bist_sequencer.md
Name: ram_bist_sequencer

Overview:
Upstream driver for the 16K x 16 RAM (14-bit address, 16-bit data). Runs one command at a time over a contiguous address range. FILL mode writes an arithmetic data pattern. VERIFY mode reads the range back, checks it against the same pattern, and reports an error count and the first failing address. Used for memory bring-up and self-test ahead of the RAM.

Parameters:
AW, 14, RAM address width
DW, 16, RAM data width
RD_LAT, 1, cycles from the read-strobe cycle until ram_dout is valid (1..4)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
mode  in  1  0 = FILL, 1 = VERIFY; latched with start
base_adr  in  AW  first address; latched with start
len  in  AW+1  number of words, 0..2^AW; latched with start
seed  in  DW  pattern value for word 0; latched with start
step  in  DW  pattern increment; latched with start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at command end
ram_e  out  1  RAM enable; high only in access cycles
ram_adr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_w  out  1  write strobe (FILL access cycles)
ram_r  out  1  read strobe (VERIFY access cycles)
ram_dout  in  DW  RAM read data
err_cnt  out  AW+1  mismatch count for the last VERIFY
first_err_adr  out  AW  address of the first mismatch
err_flag  out  1  high if err_cnt is non-zero

Behaviour:
- Reset values:
  - All outputs are 0; state is IDLE.
  - Reset mid-command aborts immediately. No further RAM strobes are issued and no done pulse is produced.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches the command, clears err_cnt, first_err_adr and err_flag, and clears the word index i.
  - Next state is RUN if len != 0, else DONE.
- RUN, one access per cycle:
  - ram_e=1.
  - ram_adr = (base_adr + i) mod 2^AW. The address wraps; there is no error on wrap.
  - Expected data for word i = seed + i*step mod 2^DW. Compute it incrementally by adding step each cycle; no multiplier.
  - FILL: ram_w=1, ram_r=0, ram_din = expected data.
  - VERIFY: ram_r=1, ram_w=0, ram_din=0.
  - Exit after i = len-1: FILL goes to DONE; VERIFY goes to DRAIN.
- DRAIN (VERIFY only):
  - Held for RD_LAT cycles with ram_e/ram_w/ram_r=0.
  - Lets the last reads return.
- Compare pipeline (VERIFY only):
  - Expected data and address are delayed RD_LAT cycles alongside each read.
  - When a delayed read is valid and ram_dout != expected, err_cnt increments.
  - On the first mismatch only, first_err_adr takes the delayed address.
  - err_flag is registered with err_cnt.
  - The compare of the final word lands no later than the last DRAIN cycle.
- DONE: done=1 for one cycle, busy=0, then back to IDLE.
- Latency, counted from the start-sampling edge:
  - FILL: done is high in cycle len+1.
  - VERIFY: done is high in cycle len+RD_LAT+1.
  - len=0: done is high in cycle 1 with no RAM access.
- start while not in IDLE (including the DONE cycle) is ignored. Command inputs may change freely while busy.
- err_cnt, first_err_adr and err_flag hold until the next accepted start. A FILL command clears them and leaves them at 0.
- err_cnt cannot overflow, since len <= 2^AW fits in AW+1 bits.

Decomposition:
- Shared package ram_bist_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the mode constants MODE_FILL=0 and MODE_VERIFY=1;
  - the default AW/DW values, shared with the RAM.
- One sub-module, ram_bist_cmp: RD_LAT-deep shift of {valid, address, expected data}, the comparator, and the error counter / first-error capture.
- Address generation and the FSM stay in the top module.

Test Plan:
- FILL, base=5, len=4, seed=7, step=7 -> writes 7,14,21,28 to addresses 5..8 in cycles 1..4 with ram_w=1; done pulse in cycle 5; busy high in cycles 1..4.
- VERIFY of the same range against a behavioural RAM model, RD_LAT=1 -> ram_r=1 in cycles 1..4; done in cycle 6; err_cnt=0, err_flag=0.
- Corrupt address 6 to 0xFFFF and address 8 to 0 in the model, then VERIFY -> err_cnt=2, first_err_adr=6, err_flag=1.
- Wrap: FILL base=16382, len=4, seed=0, step=1 -> addresses 16382, 16383, 0, 1 with data 0..3.
- len=0 -> no RAM strobes; done in cycle 1. Also: len=16384 full sweep -> done in cycle 16385, index and counter reach 16384 without overflow.
- rst=1 in cycle 2 of a 10-word FILL -> all outputs 0 in the following cycle; no further ram_w and no done. start pulsed while busy -> ignored; the command completes with its original parameters.
